// File: rtl/sb_pkg.sv
// Shared defaults and {addr,data} entry layout for the store buffer.
// Build option: STORE_BUFFER_FWD_EN (consumed by store_buffer) enables load forwarding.
package sb_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  localparam int SB_ENTRY_W = $bits(sb_entry_t);

  // Legal depths keep pointer wrap a plain binary rollover.
  function automatic bit is_valid_depth(input int d);
    return (d >= 2) && (d <= 16) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Downstream memory write channel of the store buffer.
interface store_buffer_if
  import sb_pkg::*;
#(
  parameter int AW = SB_AW,
  parameter int DW = SB_DW
);

  // Valid/ready: a beat transfers on a rising edge where bus_valid && bus_ready;
  // the master holds bus_addr/bus_wdata stable while bus_valid && !bus_ready,
  // and bus_ready while bus_valid is low has no effect.
  logic          bus_valid;
  logic          bus_ready;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;

  modport master (
    output bus_valid,
    output bus_addr,
    output bus_wdata,
    input  bus_ready
  );

  modport slave (
    input  bus_valid,
    input  bus_addr,
    input  bus_wdata,
    output bus_ready
  );

endinterface

// File: rtl/sb_ram.sv
// Store buffer entry storage: one write port, one async read port and a
// full-array view used by the forwarding comparators.
module sb_ram
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int W     = SB_ENTRY_W,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [PW-1:0]           waddr,
  input  logic [W-1:0]            wdata,
  input  logic [PW-1:0]           raddr,
  output logic [W-1:0]            rdata,
  output logic [DEPTH-1:0][W-1:0] mem_view
);

  // Contents are qualified by the buffer's count, so no reset is needed.
  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [DEPTH-1:0][W-1:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata    = mem_q[raddr];
  assign mem_view = mem_q;

endmodule

// File: rtl/store_buffer.sv
// In-order write-combining-free store buffer draining to memory over store_buffer_if.
// Build option: define STORE_BUFFER_FWD_EN to build load-forwarding comparators.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           MemWrite,
  input  logic [AW-1:0]  DataAdr,
  input  logic [DW-1:0]  WriteData,
  output logic           stall,
  store_buffer_if.master bus,
  output logic           overflow,
  input  logic [AW-1:0]  ld_addr,
  output logic           fwd_hit,
  output logic [DW-1:0]  fwd_data,
  output logic           empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + DW;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  if (!is_valid_depth(DEPTH)) begin : g_bad_depth
    $error("store_buffer: DEPTH must be a power of two in 2..16");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic                    full;
  logic                    push;
  logic                    pop;
  logic [EW-1:0]           head;
  logic [DEPTH-1:0][EW-1:0] mem_view;

  // Full comes from the registered count only, so a same-cycle pop never
  // frees a slot for the incoming store.
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = MemWrite && !full;
  assign pop   = !empty && bus.bus_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (MemWrite && full);
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  sb_ram #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_ram (
    .clk      (clk),
    .we       (push),
    .waddr    (wr_ptr_q),
    .wdata    ({DataAdr, WriteData}),
    .raddr    (rd_ptr_q),
    .rdata    (head),
    .mem_view (mem_view)
  );

  assign stall         = full;
  assign overflow      = overflow_q;
  assign bus.bus_valid = !empty;
  assign bus.bus_addr  = empty ? '0 : head[EW-1 -: AW];
  assign bus.bus_wdata = empty ? '0 : head[DW-1:0];

`ifdef STORE_BUFFER_FWD_EN
  // Scan oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) &&
          (mem_view[rd_ptr_q + PW'(i)][EW-1 -: AW] == ld_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = mem_view[rd_ptr_q + PW'(i)][DW-1:0];
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{ld_addr, mem_view};
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed plus randomized bench for store_buffer; a queue model predicts
// every output and the drain order, with or without STORE_BUFFER_FWD_EN.
module tb_store_buffer;
  import sb_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int EW    = AW + DW;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          MemWrite = 1'b0;
  logic [AW-1:0] DataAdr = '0;
  logic [DW-1:0] WriteData = '0;
  logic [AW-1:0] ld_addr = '0;
  logic          stall;
  logic          overflow;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          empty;

  always #5 clk = ~clk;

  store_buffer_if #(.AW(AW), .DW(DW)) bus_if ();

  store_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .stall     (stall),
    .bus       (bus_if),
    .overflow  (overflow),
    .ld_addr   (ld_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .empty     (empty)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] exp_q[$];
  logic          exp_ovf = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs with the model, then apply this cycle's inputs
  // to the model (they are stable until the next rising edge).
  always @(negedge clk) begin : monitor
    logic [EW-1:0] head_e;
    logic [EW-1:0] popped;
    logic          hit_e;
    logic [DW-1:0] fwd_e;
    logic          full_e;
    if (reset) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end
    head_e = (exp_q.size() != 0) ? exp_q[0] : '0;
    chk("empty",     empty,             exp_q.size() == 0);
    chk("bus_valid", bus_if.bus_valid,  exp_q.size() != 0);
    chk("stall",     stall,             exp_q.size() == DEPTH);
    chk("overflow",  overflow,          exp_ovf);
    chk("bus_addr",  bus_if.bus_addr,   head_e[EW-1 -: AW]);
    chk("bus_wdata", bus_if.bus_wdata,  head_e[DW-1:0]);
    hit_e = 1'b0;
    fwd_e = '0;
`ifdef STORE_BUFFER_FWD_EN
    foreach (exp_q[i]) begin
      if (exp_q[i][EW-1 -: AW] == ld_addr) begin
        hit_e = 1'b1;
        fwd_e = exp_q[i][DW-1:0];
      end
    end
`endif
    chk("fwd_hit",  fwd_hit,  hit_e);
    chk("fwd_data", fwd_data, fwd_e);
    if (!reset) begin
      full_e = (exp_q.size() == DEPTH);
      if (bus_if.bus_ready && exp_q.size() != 0) begin
        popped = exp_q.pop_front();
        chk("drain_order", {bus_if.bus_addr, bus_if.bus_wdata}, popped);
      end
      if (MemWrite) begin
        if (full_e) exp_ovf = 1'b1;
        else        exp_q.push_back({DataAdr, WriteData});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic mw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic rdy);
    MemWrite         = mw;
    DataAdr          = a;
    WriteData        = d;
    bus_if.bus_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) step(1'b0, '0, '0, rdy);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2, 1'b0);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus_if.bus_ready = 1'b0;
    @(posedge clk);
    #1;
    idle(2, 1'b0);
    reset = 1'b0;

    // Single store: latency 1, held while not accepted, then drained.
    step(1'b1, 32'h10, 32'hAAAA0001, 1'b0);
    chk("t_single_valid", bus_if.bus_valid, 1'b1);
    chk("t_single_addr",  bus_if.bus_addr,  32'h10);
    idle(5, 1'b0);
    chk("t_single_hold_addr", bus_if.bus_addr,  32'h10);
    chk("t_single_hold_data", bus_if.bus_wdata, 32'hAAAA0001);
    step(1'b0, '0, '0, 1'b1);
    chk("t_single_empty", empty, 1'b1);

    // Fill, overflow on a fifth store, then drain in order.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h100 + 4 * i, $urandom, 1'b0);
    chk("t_fill_stall", stall, 1'b1);
    step(1'b1, 32'h200, 32'hDEAD0000, 1'b0);
    chk("t_fill_overflow", overflow, 1'b1);
    chk("t_fill_stall_hold", stall, 1'b1);
    idle(DEPTH, 1'b1);
    chk("t_fill_drained", empty, 1'b1);
    chk("t_fill_ovf_sticky", overflow, 1'b1);

    // Asynchronous reset mid-drain with three entries held.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h600 + 4 * i, $urandom, 1'b0);
    bus_if.bus_ready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("t_arst_valid",    bus_if.bus_valid, 1'b0);
    chk("t_arst_empty",    empty,            1'b1);
    chk("t_arst_overflow", overflow,         1'b0);
    chk("t_arst_stall",    stall,            1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b1, 32'h40, 32'h1234, 1'b0);
    chk("t_arst_new_addr", bus_if.bus_addr,  32'h40);
    chk("t_arst_new_data", bus_if.bus_wdata, 32'h1234);
    idle(1, 1'b1);
    chk("t_arst_new_empty", empty, 1'b1);

    // Steady state at two entries: push and pop together across pointer wrap.
    step(1'b1, 32'h300, $urandom, 1'b0);
    step(1'b1, 32'h304, $urandom, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h308 + 4 * i, $urandom, 1'b1);
      chk("t_pp_not_full",  stall, 1'b0);
      chk("t_pp_not_empty", empty, 1'b0);
    end
    idle(3, 1'b1);

    // Forwarding: youngest of two matching stores wins.
    step(1'b1, 32'h20, 32'h1, 1'b0);
    step(1'b1, 32'h20, 32'h2, 1'b0);
    ld_addr = 32'h20;
    #1;
`ifdef STORE_BUFFER_FWD_EN
    chk("t_fwd_hit",  fwd_hit,  1'b1);
    chk("t_fwd_data", fwd_data, 32'h2);
`else
    chk("t_fwd_hit_off",  fwd_hit,  1'b0);
    chk("t_fwd_data_off", fwd_data, 32'h0);
`endif
    ld_addr = 32'h24;
    #1;
    chk("t_fwd_miss", fwd_hit, 1'b0);
    idle(3, 1'b1);

    // Full with simultaneous pop and store: store still dropped.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h500 + 4 * i, $urandom, 1'b0);
    step(1'b1, 32'h5F0, 32'h55, 1'b1);
    chk("t_fullpp_overflow", overflow, 1'b1);
    chk("t_fullpp_stall",    stall,    1'b0);
    idle(DEPTH, 1'b1);
    chk("t_fullpp_empty", empty, 1'b1);

    // Randomized traffic over a small address set to exercise forwarding.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      ld_addr = 32'h20 + 4 * $urandom_range(0, 3);
      step($urandom_range(0, 99) < 60, 32'h20 + 4 * $urandom_range(0, 3), $urandom,
           $urandom_range(0, 99) < 45);
    end
    idle(DEPTH + 2, 1'b1);
    chk("t_rand_final_empty", empty, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4: number of buffered stores; SHALL be a power of two, 2..16.
REQ-002 Parameter AW, default 32: address width.
REQ-003 Parameter DW, default 32: data width.
REQ-004 Port clk, input, 1: single clock, all state on rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port MemWrite, input, 1: store request from core, one per cycle.
REQ-007 Port DataAdr, input, AW: store address from core.
REQ-008 Port WriteData, input, DW: store data from core.
REQ-009 Port stall, output, 1: buffer full, core SHALL hold its store.
REQ-010 Port bus_valid, output, 1: head entry offered to downstream memory.
REQ-011 Port bus_ready, input, 1: downstream accepts head entry.
REQ-012 Port bus_addr, output, AW / bus_wdata, output, DW: head entry contents.
REQ-013 Port overflow, output, 1: sticky flag, store dropped while full.
REQ-014 Port ld_addr, input, AW / fwd_hit, output, 1 / fwd_data, output, DW: load-forwarding lookup.
REQ-015 Port empty, output, 1: no entries held.

Function
REQ-016 In-order FIFO of {addr,data}; entries drain strictly oldest-first.
REQ-017 Push when MemWrite=1 and count<DEPTH; pop when bus_valid=1 and bus_ready=1.
REQ-018 stall = (count==DEPTH), derived from registered count only.
REQ-019 MemWrite=1 while full: store dropped, overflow set to 1 and held until reset; count unchanged unless a pop occurs.
REQ-020 Push and pop in same cycle with 0<count<DEPTH: count unchanged, both pointers advance.
REQ-021 Push into empty buffer at edge N: bus_valid=1 with that entry from cycle N+1 (latency 1).
REQ-022 bus_valid = !empty; bus_addr/bus_wdata SHALL remain stable while bus_valid=1 and bus_ready=0.
REQ-023 bus_ready while empty: no effect.
REQ-024 Read/write pointers wrap modulo DEPTH; count width log2(DEPTH)+1.
REQ-025 Full with simultaneous pop and MemWrite: store still dropped (stall registered), pop occurs, overflow set.

Reset
REQ-026 reset=1 asynchronously clears pointers and count, and sets overflow=0, stall=0, bus_valid=0, empty=1, fwd_hit=0.
REQ-027 Entries in flight at reset are discarded; storage array contents need not be cleared.
REQ-028 bus_addr, bus_wdata, fwd_data read 0 while empty.

Configuration
REQ-029 Macro STORE_BUFFER_FWD_EN defined: fwd_hit=1 when any valid entry has addr==ld_addr; fwd_data = youngest matching entry, combinational.
REQ-030 STORE_BUFFER_FWD_EN undefined: fwd_hit=0, fwd_data=0, no comparators built; ports retained.

Structure
REQ-031 Package sb_pkg SHALL hold default DEPTH/AW/DW constants and the entry struct/width constant {addr,data}.
REQ-032 Storage SHALL be sub-module sb_ram (DEPTH x (AW+DW), 1 write port, 1 async read port, plus full-array view for forwarding).

Verification
REQ-033 Reset, push 0x10/0xAAAA0001 with bus_ready=0 -> next cycle bus_valid=1, bus_addr=0x10, held 5 cycles; ready=1 -> empty=1 next cycle.
REQ-034 Push 4 stores (DEPTH=4), ready=0 -> stall=1; 5th store dropped, overflow=1; drain yields 4 stores in order.
REQ-035 count=2, push+pop same cycle for 10 cycles -> count stays 2, order preserved across pointer wrap.
REQ-036 FWD_EN: store 0x20/1 then 0x20/2, ld_addr=0x20 -> fwd_hit=1, fwd_data=2; ld_addr=0x24 -> fwd_hit=0.
REQ-037 Assert reset mid-drain with 3 entries -> immediately bus_valid=0, empty=1, overflow=0; new push after release drains correctly.
